// File: rtl/th_disp_pkg.sv
// ---------------------------------------------------------------------------
// th_disp_pkg: segment codes, digit map and conversion states for th_seg_display
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package th_disp_pkg;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam logic [2:0] DIG_T_HUN = 3'd6;
  localparam logic [2:0] DIG_T_TEN = 3'd5;
  localparam logic [2:0] DIG_T_UNI = 3'd4;
  localparam logic [2:0] DIG_H_HUN = 3'd2;
  localparam logic [2:0] DIG_H_TEN = 3'd1;
  localparam logic [2:0] DIG_H_UNI = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WRITE = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd8.sv
// ---------------------------------------------------------------------------
// bin2bcd8: sequential double-dabble, 8-bit binary to 3-digit BCD, 8 iterations
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bin2bcd8 (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  logic [7:0]  bin_sh;
  logic [11:0] bcd_sh;
  logic [2:0]  iter;
  logic        busy;

  function automatic logic [11:0] adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bin_sh <= '0;
      bcd_sh <= '0;
      iter   <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      bin_sh <= bin;
      bcd_sh <= '0;
      iter   <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      {bcd_sh, bin_sh} <= {adjust(bcd_sh), bin_sh} << 1;
      iter             <= iter + 3'd1;
      if (iter == 3'd7) busy <= 1'b0;
    end
  end

  // High during the cycle whose edge completes the final iteration
  assign done = busy && (iter == 3'd7);
  assign bcd  = bcd_sh;

endmodule

`default_nettype wire

// File: rtl/th_seg_display.sv
// ---------------------------------------------------------------------------
// th_seg_display: temperature/humidity BCD conversion and 8-digit 7-seg scan
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module th_seg_display #(
  parameter int CLK_HZ   = 100000000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [7:0] temperature,
  input  logic [7:0] humidity,
  input  logic       alarm,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       conv_busy
);
  import th_disp_pkg::*;

  localparam int DWELL   = CLK_HZ / SCAN_HZ;
  localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
  localparam int PRESC_W = $clog2(DWELL);
  localparam int BLINK_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DWELL - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(HALF - 1);

  conv_state_t state, state_nx;
  logic        start;
  logic [7:0]  t_snap, h_snap;
  logic        first_flag;
  logic [11:0] t_bcd, h_bcd, t_disp, h_disp;
  logic        t_done, h_done;

  bin2bcd8 u_t_bcd (.clk_in(clk_in), .rst_n(rst_n), .start(start), .bin(temperature),
                    .bcd(t_bcd), .done(t_done));
  bin2bcd8 u_h_bcd (.clk_in(clk_in), .rst_n(rst_n), .start(start), .bin(humidity),
                    .bcd(h_bcd), .done(h_done));

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (temperature != t_snap || humidity != h_snap || first_flag) begin
          start    = 1'b1;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: if (t_done && h_done) state_nx = ST_WRITE;
      ST_WRITE: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      t_snap     <= '0;
      h_snap     <= '0;
      first_flag <= 1'b1;
      conv_busy  <= 1'b0;
      t_disp     <= '0;
      h_disp     <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        t_snap     <= temperature;
        h_snap     <= humidity;
        first_flag <= 1'b0;
        conv_busy  <= 1'b1;
      end
      if (state == ST_WRITE) begin
        t_disp    <= t_bcd;
        h_disp    <= h_bcd;
        conv_busy <= 1'b0;
      end
    end
  end

  logic [PRESC_W-1:0] presc;
  logic [2:0]         idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      if (presc == PRESC_MAX) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  logic       blink_off, blank;
  logic [3:0] val;
  logic [6:0] seg_nx;

  always_comb begin
    blink_off = alarm && phase;
    val       = 4'd0;
    blank     = 1'b1;
    case (idx)
      DIG_T_HUN: begin val = t_disp[11:8]; blank = (t_disp[11:8] == 4'd0) || blink_off; end
      DIG_T_TEN: begin val = t_disp[7:4];  blank = (t_disp[11:4] == 8'd0) || blink_off; end
      DIG_T_UNI: begin val = t_disp[3:0];  blank = blink_off; end
      DIG_H_HUN: begin val = h_disp[11:8]; blank = (h_disp[11:8] == 4'd0); end
      DIG_H_TEN: begin val = h_disp[7:4];  blank = (h_disp[11:4] == 8'd0); end
      DIG_H_UNI: begin val = h_disp[3:0];  blank = 1'b0; end
      default:   begin val = 4'd0;         blank = 1'b1; end
    endcase
    seg_nx = blank ? SEG_BLANK : seg_encode(val);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(8'd1 << idx);
      seg <= seg_nx;
    end
  end

  assign dp = 1'b1;

endmodule

`default_nettype wire

// File: doc/th_seg_display.md
Name: th_seg_display

Overview:
Downstream consumer of the DHT11 temperature/humidity capture stage. Converts the 8-bit binary temperature and humidity values to 3-digit BCD using a sequential double-dabble converter. Drives the NEXYS 4 8-digit multiplexed 7-segment display. Temperature digits blink while the over-temperature alarm is asserted.

Parameters:
CLK_HZ, 100000000, clk_in frequency in Hz
SCAN_HZ, 1000, per-digit dwell rate; dwell = CLK_HZ/SCAN_HZ cycles (integer, >=2)
BLINK_HZ, 2, alarm blink toggle rate; half-period = CLK_HZ/(2*BLINK_HZ) cycles

Ports:
clk_in  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
temperature  input  8  binary temperature, degC, from capture stage
humidity  input  8  binary relative humidity, %, from capture stage
alarm  input  1  over-temperature flag (level), from capture stage
an  output  8  digit anodes, active-low one-hot; an[7] leftmost
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low; held 1 (off)
conv_busy  output  1  high while a BCD conversion is in progress

Behaviour:
- Reset (async, rst_n=0):
  - an=8'hFF, seg=7'h7F, dp=1, conv_busy=0.
  - Snapshot regs and BCD display regs = 0; digit index = 0; prescaler and blink counters = 0; blink phase = 0.
  - first_flag = 1, forcing one conversion after reset release.
- Conversion control, states IDLE / SHIFT / WRITE:
  - IDLE -> SHIFT at cycle S when (temperature != t_snap || humidity != h_snap || first_flag).
  - At S: t_snap/h_snap capture the inputs, shift regs load them, iteration count = 0, conv_busy = 1, first_flag cleared.
  - SHIFT: one double-dabble iteration per cycle (add 3 to any BCD nibble >=5, then shift left 1). Both values convert in parallel. Runs cycles S+1..S+8.
  - WRITE at S+9: 12-bit BCD results are copied to the display regs, conv_busy = 0, return to IDLE.
  - Total latency from input change to display regs updated: 10 cycles.
  - Inputs changing during SHIFT/WRITE are ignored until IDLE. The snapshot compare then retriggers, so the final value is always displayed.
  - Display regs change only in WRITE; no partial values are ever shown.
- Scan:
  - Prescaler counts 0..CLK_HZ/SCAN_HZ-1. On wrap, digit index increments 0..7, and 7 wraps to 0.
  - an and seg are registered: they reflect the new index 1 cycle after the wrap.
- Digit map (index -> anode):
  - 7: blank
  - 6: temperature hundreds
  - 5: temperature tens
  - 4: temperature units
  - 3: blank
  - 2: humidity hundreds
  - 1: humidity tens
  - 0: humidity units
  - The selected anode is driven low even when the digit is blank; blank digits use seg=7'h7F.
- Leading-zero blanking per value:
  - hundreds blank if 0;
  - tens blank if hundreds=0 and tens=0;
  - units always shown.
- Segment codes, 0..9: 40,79,24,30,19,12,02,78,00,10 (hex, 7-bit).
- Alarm blink:
  - Blink counter runs continuously; blink phase toggles each half-period.
  - When alarm=1 and phase=1, digits 6..4 output seg=7'h7F.
  - When alarm=0, digits display normally with no phase dependence.
  - alarm is sampled combinationally into the registered seg.
- Reset mid-conversion: the async reset aborts it immediately; after release the display shows "  0   0" until the forced conversion's WRITE.

Decomposition:
- Package th_disp_pkg holds:
  - 7-segment digit code constants and SEG_BLANK;
  - digit-index-to-field map constants;
  - conversion state encoding.
- Sub-module bin2bcd8: start/done sequential double-dabble, 8-bit in, 12-bit BCD out, 9-cycle latency. Instantiated twice, sharing start.
- Top level holds change detection, WRITE, scan, blink and segment decode.

Test Plan:
- Reset, then release with temperature=25, humidity=60 -> conv_busy=1 for cycles S..S+8; display regs = 12'h025 / 12'h060 at S+9; digit 5 seg=24, digit 4 seg=12, digit 6 seg=7F, digit 1 seg=02, digit 0 seg=40.
- temperature=255, humidity=100 -> "255" with seg 24,12,12; "100" with seg 79,40,40 (tens zero shown because hundreds is nonzero).
- temperature=0, humidity=5 -> digits 6,5,3,2,1 seg=7F; digit 4 seg=40; digit 0 seg=12.
- Change temperature 20 -> 31 at S+3 of an active conversion -> first WRITE shows 020; a second conversion starts right after and shows 031 at most 10 cycles later. Displayed tens never show a partial value.
- With CLK_HZ=1000, SCAN_HZ=100, BLINK_HZ=10 -> an steps FE,FD,...,7F every 10 cycles and wraps. With alarm=1, digits 6..4 alternate shown/blank every 50 cycles; digits 2..0 are unaffected.
- Assert rst_n=0 at S+4 -> an=FF, seg=7F, conv_busy=0 immediately. After release the forced conversion runs and the current inputs are displayed at S'+9.
